// File: rtl/otter_pipe_pkg.sv
// Shared types and helpers for the OTTER hazard/forwarding logic.
package otter_pipe_pkg;

    // One shadow-pipeline slot: a pending register write travelling down the pipe.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } hz_entry_t;

    // Forward-select value meaning "take the operand from the register file".
    localparam int FWD_RF = 0;

    // Select width: wide enough to encode 0 (register file) plus stages 1..nstages.
    function automatic int selw(input int nstages);
        return $clog2(nstages + 1);
    endfunction

endpackage

// File: rtl/otter_fwd_match.sv
// One decode source operand checked against every in-flight destination.
// The youngest matching stage decides between forwarding and stalling.
module otter_fwd_match
    import otter_pipe_pkg::*;
#(
    parameter int NSTAGES    = 3,
    parameter int LOAD_READY = 3,
    parameter int FWD_EN     = 1,
    parameter int SELW       = 2
) (
    input  logic                    dec_valid,
    input  logic [4:0]              rs,
    input  logic                    rs_used,
    input  hz_entry_t [NSTAGES-1:0] entries,   // index 0 is stage 1 (EX)
    output logic                    stall_req,
    output logic [SELW-1:0]         sel
);

    logic hit;

    // Scan youngest to oldest; the first hit wins, later hits are shadowed.
    always_comb begin
        stall_req = 1'b0;
        sel       = SELW'(FWD_RF);
        hit       = 1'b0;
        for (int k = 0; k < NSTAGES; k++) begin
            if (!hit && dec_valid && rs_used && (rs != 5'd0) &&
                entries[k].valid && (entries[k].rd == rs)) begin
                hit = 1'b1;
                // Load data only exists from LOAD_READY onward; without
                // forwarding nothing in flight is usable.
                if ((FWD_EN != 0) && !(entries[k].is_load && ((k + 1) < LOAD_READY)))
                    sel = SELW'(k + 1);
                else
                    stall_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/otter_hazard_unit.sv
// Hazard and forwarding unit: shadow pipeline of pending writes, per-operand
// forward selects, a global stall and a saturating stall-cycle counter.
module otter_hazard_unit
    import otter_pipe_pkg::*;
#(
    parameter int  NSTAGES    = 3,
    parameter int  NSRC       = 2,
    parameter int  LOAD_READY = 3,
    parameter int  FWD_EN     = 1,
    parameter int  CNT_W      = 16,
    localparam int SELW       = selw(NSTAGES)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   DEC_VALID,
    input  logic [NSRC*5-1:0]      DEC_RS,
    input  logic [NSRC-1:0]        DEC_RS_USED,
    input  logic [4:0]             DEC_RD,
    input  logic                   DEC_WE,
    input  logic                   DEC_IS_LOAD,
    input  logic                   FLUSH,
    output logic                   STALL,
    output logic [NSRC*SELW-1:0]   FWD_SEL,
    output logic [NSTAGES-1:0]     STAGE_VALID,
    output logic [CNT_W-1:0]       STALL_CNT
);

    hz_entry_t [NSTAGES-1:0]      entry_q, entry_d;
    logic                         init_q, init_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NSRC-1:0]              stall_req;
    logic [NSRC-1:0][SELW-1:0]    sel;
    logic                         stall;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        otter_fwd_match #(
            .NSTAGES    (NSTAGES),
            .LOAD_READY (LOAD_READY),
            .FWD_EN     (FWD_EN),
            .SELW       (SELW)
        ) u_match (
            .dec_valid (DEC_VALID),
            .rs        (DEC_RS[5*i +: 5]),
            .rs_used   (DEC_RS_USED[i]),
            .entries   (entry_q),
            .stall_req (stall_req[i]),
            .sel       (sel[i])
        );
    end

    // init_q marks the first cycle out of reset, where outputs are held quiet.
    assign stall       = (|stall_req) & ~FLUSH & ~init_q;
    assign STALL       = stall;
    assign FWD_SEL     = init_q ? '0 : sel;
    assign STALL_CNT   = cnt_q;

    // Debug view of the shadow valid bits.
    always_comb begin
        STAGE_VALID = '0;
        for (int k = 0; k < NSTAGES; k++)
            STAGE_VALID[k] = entry_q[k].valid & ~init_q;
    end

    // Advance the shadow pipe; a stalled or flushed decode slot becomes a bubble.
    always_comb begin
        entry_d = '0;
        for (int k = 1; k < NSTAGES; k++)
            entry_d[k] = entry_q[k-1];
        if (DEC_VALID && DEC_WE && (DEC_RD != 5'd0) && !stall && !FLUSH) begin
            entry_d[0].valid   = 1'b1;
            entry_d[0].rd      = DEC_RD;
            entry_d[0].is_load = DEC_IS_LOAD;
        end
    end

    // Next values for the init flag and the saturating stall counter.
    always_comb begin
        init_d = 1'b0;
        cnt_d  = cnt_q;
        if (stall && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            entry_q <= '0;
            init_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            entry_q <= entry_d;
            init_q  <= init_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Scoreboard bench for otter_hazard_unit: a forwarding build (defaults) and a
// no-forward build with a narrow counter to exercise saturation.
module tb_otter_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v, we, ld, fl;
    logic [9:0]  rs;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        st;
    logic [3:0]  sel;
    logic [2:0]  sv;
    logic [15:0] cnt;

    logic        n_v, n_we, n_ld, n_fl;
    logic [9:0]  n_rs;
    logic [1:0]  n_used;
    logic [4:0]  n_rd;
    logic        n_st;
    logic [3:0]  n_sel;
    logic [2:0]  n_sv;
    logic [3:0]  n_cnt;

    always #5 clk = ~clk;

    otter_hazard_unit u_dut (
        .CLK(clk), .RST(rst), .DEC_VALID(v), .DEC_RS(rs), .DEC_RS_USED(used),
        .DEC_RD(rd), .DEC_WE(we), .DEC_IS_LOAD(ld), .FLUSH(fl),
        .STALL(st), .FWD_SEL(sel), .STAGE_VALID(sv), .STALL_CNT(cnt)
    );

    otter_hazard_unit #(.FWD_EN(0), .CNT_W(4)) u_nf (
        .CLK(clk), .RST(rst), .DEC_VALID(n_v), .DEC_RS(n_rs), .DEC_RS_USED(n_used),
        .DEC_RD(n_rd), .DEC_WE(n_we), .DEC_IS_LOAD(n_ld), .FLUSH(n_fl),
        .STALL(n_st), .FWD_SEL(n_sel), .STAGE_VALID(n_sv), .STALL_CNT(n_cnt)
    );

    typedef struct {
        string       name;
        bit          inst;
        bit          c_st, c_sel, c_sv, c_cnt;
        logic        st;
        logic [3:0]  sel;
        logic [2:0]  sv;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Expected value of -1 means "not checked this cycle".
    task automatic push(input string nm, input bit inst, input int e_st,
                        input int e_sel, input int e_sv, input int e_cnt);
        exp_t e;
        e.name = nm;   e.inst = inst;
        e.c_st = (e_st >= 0);   e.st  = e_st[0];
        e.c_sel = (e_sel >= 0); e.sel = e_sel[3:0];
        e.c_sv = (e_sv >= 0);   e.sv  = e_sv[2:0];
        e.c_cnt = (e_cnt >= 0); e.cnt = e_cnt[15:0];
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit inst, input logic vv, input logic [4:0] r1,
                         input logic [4:0] r0, input logic [1:0] u, input logic [4:0] d,
                         input logic w, input logic l, input logic f);
        if (inst == 1'b0) begin
            v = vv; rs = {r1, r0}; used = u; rd = d; we = w; ld = l; fl = f;
        end else begin
            n_v = vv; n_rs = {r1, r0}; n_used = u; n_rd = d; n_we = w; n_ld = l; n_fl = f;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so every pending expectation is
    // compared on the falling edge of the cycle it was issued in.
    always @(negedge clk) begin
        exp_t        e;
        logic        a_st;
        logic [3:0]  a_sel;
        logic [2:0]  a_sv;
        logic [15:0] a_cnt;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.inst == 1'b0) begin
                a_st = st; a_sel = sel; a_sv = sv; a_cnt = cnt;
            end else begin
                a_st = n_st; a_sel = n_sel; a_sv = n_sv; a_cnt = {12'd0, n_cnt};
            end
            if (e.c_st) begin
                checks++;
                if (a_st !== e.st) begin
                    errors++;
                    $display("FAIL %s STALL: got %b want %b", e.name, a_st, e.st);
                end
            end
            if (e.c_sel) begin
                checks++;
                if (a_sel !== e.sel) begin
                    errors++;
                    $display("FAIL %s FWD_SEL: got %b want %b", e.name, a_sel, e.sel);
                end
            end
            if (e.c_sv) begin
                checks++;
                if (a_sv !== e.sv) begin
                    errors++;
                    $display("FAIL %s STAGE_VALID: got %b want %b", e.name, a_sv, e.sv);
                end
            end
            if (e.c_cnt) begin
                checks++;
                if (a_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL %s STALL_CNT: got %0d want %0d", e.name, a_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state and the quiet first cycle after release.
        cyc();  push("rst_hold", 0, 0, 0, 0, 0);  push("rst_hold_nf", 1, 0, 0, 0, 0);
        cyc();  rst = 1'b0;  push("post_rst", 0, 0, 0, 0, 0);

        // ALU back-to-back, one- and two-instruction gaps, mixed stages.
        cyc(); drive(0, 1, 0, 0, 2'b00, 5, 1, 0, 0);   push("alu_prod", 0, 0, 0, 0, 0);
        cyc(); drive(0, 1, 5, 5, 2'b11, 6, 1, 0, 0);   push("b2b_fwd", 0, 0, 4'b0101, 3'b001, 0);
        cyc(); drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);   push("idle_rf", 0, 0, 0, 3'b011, 0);
        cyc(); drive(0, 1, 0, 0, 2'b00, 9, 1, 0, 0);   push("gap_prod", 0, 0, 0, 3'b110, 0);
        cyc(); drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);   push("gap_bub", 0, 0, 0, 3'b101, 0);
        cyc(); drive(0, 1, 0, 9, 2'b01, 10, 1, 0, 0);  push("gap1_fwd2", 0, 0, 4'b0010, 3'b010, 0);
        cyc(); drive(0, 1, 10, 9, 2'b11, 0, 1, 0, 0);  push("mix_fwd_1_3", 0, 0, 4'b0111, 3'b101, 0);

        // x0 is never tracked and never matched.
        cyc(); drive(0, 1, 0, 0, 2'b11, 0, 1, 0, 0);   push("x0_read", 0, 0, 0, 3'b010, 0);
        cyc(); drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);   push("x0_noent", 0, 0, 0, 3'b100, 0);

        // Load-use: two stall cycles, then forward from stage 3.
        cyc(); drive(0, 1, 0, 0, 2'b00, 7, 1, 1, 0);   push("lw_prod", 0, 0, 0, 3'b000, 0);
        cyc(); drive(0, 1, 0, 7, 2'b11, 8, 1, 0, 0);   push("lu_stall1", 0, 1, -1, 3'b001, 0);
        cyc();                                         push("lu_stall2", 0, 1, -1, 3'b010, 1);
        cyc();                                         push("lu_fwd3", 0, 0, 4'b0011, 3'b100, 2);
        cyc(); drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);   push("lu_done", 0, 0, 0, 3'b001, 2);

        // FLUSH in the first load-use stall cycle kills the stall and the slot.
        cyc(); drive(0, 1, 0, 0, 2'b00, 11, 1, 1, 0);  push("lw2_prod", 0, 0, 0, 3'b010, 2);
        cyc(); drive(0, 1, 0, 11, 2'b01, 12, 1, 0, 1); push("flush_stall", 0, 0, 0, 3'b101, 2);
        cyc(); drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);   push("flush_bub", 0, 0, 0, 3'b010, 2);

        // Asynchronous reset in the middle of a load-use stall.
        cyc(); drive(0, 1, 0, 0, 2'b00, 13, 1, 1, 0);  push("lw3_prod", 0, 0, 0, 3'b100, 2);
        cyc(); drive(0, 1, 0, 13, 2'b01, 14, 1, 0, 0); push("pre_rst_stall", 0, 1, -1, 3'b001, 2);
        @(negedge clk); #2;
        rst = 1'b1;                                    push("rst_mid", 0, 0, -1, 3'b000, 0);
        cyc(); rst = 1'b0;                             push("rst_mid_after", 0, 0, 0, 3'b000, 0);
        cyc(); drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);   push("rst_mid_resume", 0, 0, 0, 3'b001, 0);

        // No-forward build: a back-to-back dependent stalls for all three stages.
        cyc(); drive(1, 1, 0, 0, 2'b00, 3, 1, 0, 0);   push("nf_prod", 1, 0, 0, 3'b000, 0);
        cyc(); drive(1, 1, 3, 3, 2'b11, 4, 1, 0, 0);   push("nf_stall1", 1, 1, -1, 3'b001, 0);
        cyc();                                         push("nf_stall2", 1, 1, -1, 3'b010, 1);
        cyc();                                         push("nf_stall3", 1, 1, -1, 3'b100, 2);
        cyc();                                         push("nf_go_rf", 1, 0, 0, 3'b000, 3);

        // Self-dependent chain: 3 stalls per 4 cycles drives the 4-bit counter to saturation.
        for (int i = 0; i < 26; i++) begin
            cyc(); drive(1, 1, 0, 4, 2'b01, 4, 1, 0, 0);
            if (i == 24) push("nf_sat", 1, 1, -1, -1, 15);
            if (i == 25) push("nf_sat_hold", 1, 1, -1, -1, 15);
        end

        cyc(); drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_hazard_unit.md
# otter_hazard_unit

Parametrised hazard and forwarding unit for the pipelined OTTER core.
- Keeps a shadow pipeline of in-flight destination registers, one entry per post-decode stage.
- Compares each decode-stage source against that shadow pipeline.
- Produces one STALL signal and one forwarding select per source operand.
- Replaces the fixed stall-only resolver with configurable depth, operand count, load latency and an optional no-forward mode; adds a stall performance counter.

## Interface
Parameters:
- NSTAGES, 3: post-decode stages tracked (1=EX, 2=MEM, 3=WB).
- NSRC, 2: source operands checked per decode instruction.
- LOAD_READY, 3: first stage index at which load data can be forwarded; legal range 1..NSTAGES.
- FWD_EN, 1: 1 = forward; 0 = stall on any pending match.
- CNT_W, 16: stall counter width.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- DEC_VALID  in  1  decode register holds a live instruction.
- DEC_RS  in  NSRC*5  source register addresses; operand i is at [5i+4:5i].
- DEC_RS_USED  in  NSRC  operand i is actually read.
- DEC_RD  in  5  destination register.
- DEC_WE  in  1  instruction writes DEC_RD.
- DEC_IS_LOAD  in  1  instruction is a load.
- FLUSH  in  1  taken branch, jump or trap; the decode instruction is dead.
- STALL  out  1  hold PC, PC_WAIT and decode registers; insert a bubble into EX.
- FWD_SEL  out  NSRC*SELW  per-operand source; 0 = register file, k = result of stage k. SELW = $clog2(NSTAGES+1).
- STAGE_VALID  out  NSTAGES  shadow entry valid, for debug.
- STALL_CNT  out  CNT_W  saturating count of stall cycles.

## Operation
- Shadow entry fields: {valid, rd, is_load}. Entries are created only when DEC_WE=1 and DEC_RD≠0.
- Every clock edge:
  - entry[k] ← entry[k-1] for k = 2..NSTAGES; the oldest entry retires.
  - entry[1] ← decode info if DEC_VALID & DEC_WE & (DEC_RD≠0) & !STALL & !FLUSH; otherwise entry[1] ← bubble.
- Match for operand i at stage k: DEC_VALID & DEC_RS_USED[i] & entry[k].valid & entry[k].rd == rs_i & rs_i ≠ 0.
- The youngest match (lowest k) decides the operand's outcome.
- Ready rule:
  - FWD_EN=1: the match is ready unless entry[k].is_load and k < LOAD_READY.
  - FWD_EN=0: the match is never ready.
- Per-operand outcome:
  - No match: FWD_SEL=0.
  - Ready match: FWD_SEL=k.
  - Not-ready match: the operand requests a stall and FWD_SEL=0.
- STALL = OR of all operand stall requests, forced to 0 when FLUSH=1. FLUSH overrides STALL.
- FWD_SEL is don't-care while STALL=1. It is 0 when DEC_VALID=0.
- STALL_CNT increments on every cycle with STALL=1 and saturates at all-ones.
- Reset (async, any time, including mid-stall):
  - all entries invalid; STALL_CNT=0.
  - STALL=0, FWD_SEL=0, STAGE_VALID=0 while RST is asserted and in the first cycle after it.

## Timing
- STALL and FWD_SEL are combinational from the DEC_* inputs and registered entries. Same-cycle use by the PC enable and the operand muxes.
- Defaults (NSTAGES=3, LOAD_READY=3, FWD_EN=1):
  - ALU→dependent back-to-back: 0 stalls, FWD_SEL=1.
  - Gap of one instruction: FWD_SEL=2.
  - Gap of two instructions: FWD_SEL=3.
  - Load→use: 2 stall cycles, then FWD_SEL=3.
- FWD_EN=0: a dependent stalls until the producer has retired past stage NSTAGES. That is NSTAGES stall cycles back-to-back.
- Both operands hitting different stages: each operand gets its own select, no extra latency.
- FLUSH during a stall: the stall drops that cycle, a bubble enters EX and the counter does not increment.

## Structure
- Package otter_pipe_pkg holds:
  - typedef hz_entry_t {valid, rd[4:0], is_load}.
  - the SELW function.
  - constant FWD_RF = 0.
- Sub-module otter_fwd_match: one operand versus all NSTAGES entries, returning {stall_req, sel}. Instantiate NSRC times via generate.
- The shift register and the counter stay in the top module.

## Test plan
- Reset with RST pulsed mid-stall → STALL=0, STAGE_VALID=000, STALL_CNT=0 immediately; no stall in the following cycle.
- ADD x5 then SUB x6,x5,x5 back-to-back → no stall; FWD_SEL = {1,1}.
- LW x7 then ADD x8,x7,x0 → STALL=1 for exactly 2 cycles; then FWD_SEL[0]=3; STALL_CNT=2.
- Writes to x0 followed by reads of x0 → never a stall, FWD_SEL=0.
- FWD_EN=0 build with ADD x3 then OR x4,x3,x3 → STALL for 3 cycles, then FWD_SEL=0.
- Load-use stall with FLUSH asserted in the first stall cycle → STALL=0 that cycle; entry[1] becomes a bubble; STALL_CNT unchanged; STALL_CNT saturates at 0xFFFF under a forced long stall (CNT_W=16).
